// File: rtl/mdu.sv
// Multiply/divide unit: issues MULT/MULTU/DIV/DIVU with a fixed busy countdown,
// and performs MTHI/MTLO in a single edge. HI/LO hold only committed results.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_count;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_issue;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_commit;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_divisor_u;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_issue      = 1'b1;
                            w_next_state = S_BUSY;
                        end
                        OP_MTHI: w_mthi = 1'b1;
                        OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (r_count <= 16'd1) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Sign-extending to 64 bits lets one unsigned multiplier produce the signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    assign w_div_zero  = (r_b == 32'd0);
    assign w_divisor_u = w_div_zero ? 32'd1 : r_b;
    assign w_quot_u    = r_a / w_divisor_u;
    assign w_rem_u     = r_a % w_divisor_u;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
    assign w_abs_a  = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_abs_b  = r_b[31] ? (~r_b + 32'd1) : w_divisor_u;
    assign w_mag_q  = w_abs_a / w_abs_b;
    assign w_mag_r  = w_abs_a % w_abs_b;
    assign w_quot_s = (r_a[31] ^ r_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
    assign w_rem_s  = r_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 16'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_op    <= mdu_op;
                r_a     <= rs_data;
                r_b     <= rt_data;
                r_count <= (mdu_op == OP_MULT || mdu_op == OP_MULTU) ?
                           16'(MULT_CYCLES) : 16'(DIV_CYCLES);
            end else if (r_state == S_BUSY) begin
                r_count <= r_count - 16'd1;
            end
        end
    end

    // A zero divisor still occupies the full busy period but commits nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_mthi) r_hi <= rs_data;
            if (w_mtlo) r_lo <= rs_data;
            if (w_commit) begin
                case (r_op)
                    OP_MULT: begin
                        r_hi <= w_prod_s[63:32];
                        r_lo <= w_prod_s[31:0];
                    end
                    OP_MULTU: begin
                        r_hi <= w_prod_u[63:32];
                        r_lo <= w_prod_u[31:0];
                    end
                    OP_DIV: begin
                        if (!w_div_zero) begin
                            r_hi <= w_rem_s;
                            r_lo <= w_quot_s;
                        end
                    end
                    OP_DIVU: begin
                        if (!w_div_zero) begin
                            r_hi <= w_rem_u;
                            r_lo <= w_quot_u;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the CPU datapath. Sits beside the ALU: it consumes the two register-file read operands (rs, rt), is issued by the controller for MULT/MULTU/DIV/DIVU/MTHI/MTLO, and produces HI/LO to the register write-back mux for MFHI/MFLO. Multi-cycle latency is modelled by a countdown with a `busy` flag that the stall logic uses to hold dependent instructions.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: issue strobe, sampled on the rising edge.
- `mdu_op` input, 3 bits: operation.
  - 0 = none, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO.
  - 7 = reserved, treated as none.
- `rs_data` input, 32 bits: operand A (dividend / multiplicand / MTHI/MTLO source).
- `rt_data` input, 32 bits: operand B (divisor / multiplier).
- `busy` output, 1 bit: operation in flight.
- `hi` output, 32 bits: architectural HI register.
- `lo` output, 32 bits: architectural LO register.

## Operation
- State machine has two states, IDLE and BUSY.
- **IDLE**
  - `start=1` with op 1–4: latch `rs_data`/`rt_data`, load the counter with `MULT_CYCLES` or `DIV_CYCLES`, store the op, go to BUSY.
  - `start=1` with op 5: `hi <= rs_data`. Op 6: `lo <= rs_data`. Both complete in one edge; stay in IDLE; `busy` stays 0.
  - `start=0`, or op 0/7: no change.
- **BUSY**
  - The counter decrements every edge.
  - On the edge where the counter goes 1→0: commit the result to `hi`/`lo` and return to IDLE.
  - `start` is ignored entirely while BUSY, including MTHI/MTLO. The controller must stall; the unit does not queue.
- **Results**
  - MULT: signed 32×32→64. MULTU: unsigned. `{hi,lo} = product`.
  - DIV: signed. Quotient truncates toward zero and goes to `lo`. Remainder takes the sign of the dividend and goes to `hi`.
  - DIVU: unsigned quotient to `lo`, remainder to `hi`.
  - Divisor = 0 (DIV or DIVU): the full busy period elapses; `hi`/`lo` are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- The result may be computed combinationally from the latched operands; only the commit is delayed. Operands are latched at issue, so later changes on `rs_data`/`rt_data` do not affect an in-flight result.
- `hi`/`lo` always show committed values. The in-progress result is never visible before commit.

## Timing
- **Reset:** `busy` = 0, `hi` = 0, `lo` = 0, state IDLE, counter 0.
  - Reset is asynchronous: the outputs clear immediately, not at the next edge.
  - Reset during BUSY aborts the operation; no commit occurs afterwards.
- **Busy latency:** issue sampled at edge T. `busy` is 1 after edge T through edge T+N, i.e. high for exactly N cycles.
  - At edge T+N, `hi`/`lo` update and `busy` falls together.
- **Back-to-back issue:** a new op may be issued at edge T+N+1, the first edge sampled in IDLE. No dead cycle beyond that.
- **MTHI/MTLO:** value visible on `hi`/`lo` after the issuing edge; latency 1, no busy.
- **Reads:** MFHI/MFLO read `hi`/`lo` combinationally. The controller must stall them while `busy` = 1, or while `start` = 1 with op 1–4.

## Test plan
- **Reset mid-op:** reset at edge T+3 of a DIV → `busy`, `hi`, `lo` go to 0 immediately and stay 0 after reset releases. A MULT issued afterwards behaves normally.
- **MULT:**
  - Issue MULT with rs = 0xFFFFFFFE (−2), rt = 3 → `busy` high for exactly 5 cycles. Then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
  - MULTU with the same operands → `hi` = 0x00000002, `lo` = 0xFFFFFFFA.
- **DIV / DIVU:**
  - DIV rs = 0xFFFFFFF9 (−7), rt = 2 → `busy` for 10 cycles, then `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - DIVU rs = 7, rt = 2 → `lo` = 3, `hi` = 1.
- **Boundary divides:**
  - Preload `hi` = 0x11, `lo` = 0x22 via MTHI/MTLO, then DIV by 0 → `busy` for 10 cycles; `hi`/`lo` still 0x11/0x22.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- **Ignored issue while busy:**
  - During a MULT, pulse `start` with MTLO rs = 0x55 and with DIV → both ignored. `lo` ends with the MULT result, and `busy` falls on the original schedule.
  - MULT issued at the first edge after `busy` falls → accepted; `busy` high for exactly 5 cycles again.
- **Operand latching:** change `rs_data`/`rt_data` every cycle while BUSY → the committed result matches the operands captured at the issuing edge.
